// File: rtl/asm18_mem_pkg.sv
// Shared types and defaults for the asm18 memory subsystem.
package asm18_mem_pkg;
  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DMA = 1'b1;

  localparam int DEF_ADDR_SIZE = 18;
  localparam int DEF_WORD_SIZE = 18;
endpackage

// File: rtl/ram_arb_pick2.sv
// Combinational 2-way picker: lone requester wins, contention goes to the
// port that did not win last (or always port 0 when fixed).
module ram_arb_pick2
  import asm18_mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_win,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (fixed || last_win == PORT_DMA) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM with a
// one-cycle read return path and per-port read-data hold registers.
module ram_arbiter
  import asm18_mem_pkg::*;
#(
  parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] din0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [WORD_SIZE-1:0] dout0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] din1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] dout1,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  input  logic [WORD_SIZE-1:0] ram_dout
);

  logic [1:0]           pick;
  port_id_t             last_win;
  port_id_t             rd_port;
  logic                 rd_pend;
  logic                 rd_go;
  logic [WORD_SIZE-1:0] hold0;
  logic [WORD_SIZE-1:0] hold1;

  ram_arb_pick2 u_pick (
    .req      ({req1, req0}),
    .last_win (last_win),
    .fixed    (FIXED_PRIORITY != 0),
    .gnt      (pick)
  );

  assign gnt0 = pick[0] & ~reset;
  assign gnt1 = pick[1] & ~reset;

  // Idle cycles leave the address/data bus parked on port 0.
  assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
  assign ram_addr = gnt1 ? addr1 : addr0;
  assign ram_din  = gnt1 ? din1  : din0;

  assign rd_go = (gnt0 & ~we0) | (gnt1 & ~we1);

  // Returning data bypasses the hold register so dout is valid with rvalid.
  assign rvalid0 = rd_pend & ~reset & (rd_port == PORT_CPU);
  assign rvalid1 = rd_pend & ~reset & (rd_port == PORT_DMA);
  assign dout0   = rvalid0 ? ram_dout : hold0;
  assign dout1   = rvalid1 ? ram_dout : hold1;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_win <= PORT_DMA;
      rd_pend  <= 1'b0;
      rd_port  <= PORT_CPU;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      if (gnt0 | gnt1)
        last_win <= gnt1 ? PORT_DMA : PORT_CPU;
      rd_pend <= rd_go;
      if (rd_go)
        rd_port <= gnt1 ? PORT_DMA : PORT_CPU;
      if (rvalid0)
        hold0 <= ram_dout;
      if (rvalid1)
        hold1 <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin instance with a 1024-word RAM model,
// plus a fixed-priority instance for the starvation case.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;

  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [17:0] addr0 = '0, din0 = '0, addr1 = '0, din1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [17:0] dout0, dout1, ram_addr, ram_din, ram_dout;

  logic        freq0 = 1'b0, freq1 = 1'b0;
  logic        fgnt0, fgnt1, frv0, frv1, fram_we;
  logic [17:0] fdout0, fdout1, fram_addr, fram_din;
  logic [17:0] fram_dout = '0;
  logic [17:0] faddr0 = 18'd1, faddr1 = 18'd2, fdin = 18'h00f0f;

  logic [17:0] mem [0:1023];
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .FIXED_PRIORITY(0)) u_rr (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .gnt0(gnt0), .rvalid0(rvalid0), .dout0(dout0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .gnt1(gnt1), .rvalid1(rvalid1), .dout1(dout1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .FIXED_PRIORITY(1)) u_fp (
    .clock(clock), .reset(reset),
    .req0(freq0), .we0(1'b1), .addr0(faddr0), .din0(fdin),
    .gnt0(fgnt0), .rvalid0(frv0), .dout0(fdout0),
    .req1(freq1), .we1(1'b1), .addr1(faddr1), .din1(fdin),
    .gnt1(fgnt1), .rvalid1(frv1), .dout1(fdout1),
    .ram_we(fram_we), .ram_addr(fram_addr), .ram_din(fram_din), .ram_dout(fram_dout)
  );

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[3]  <= 18'h00011;
      mem[5]  <= 18'h01234;
      mem[20] <= 18'h0aaaa;
      mem[21] <= 18'h15555;
    end else begin
      if (ram_we) mem[ram_addr[9:0]] <= ram_din;
      ram_dout <= mem[ram_addr[9:0]];
    end
  end

  // Scoreboard: read grants push the expected word, read returns pop it.
  always @(negedge clock) begin
    if (rvalid0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++; $display("FAIL sb_port0: rvalid0 with no read outstanding, dout0=%h", dout0);
      end else begin
        logic [17:0] e0;
        e0 = q0.pop_front();
        if (dout0 !== e0) begin
          n_err++; $display("FAIL sb_port0: dout0=%h expected %h", dout0, e0);
        end
      end
    end
    if (rvalid1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++; $display("FAIL sb_port1: rvalid1 with no read outstanding, dout1=%h", dout1);
      end else begin
        logic [17:0] e1;
        e1 = q1.pop_front();
        if (dout1 !== e1) begin
          n_err++; $display("FAIL sb_port1: dout1=%h expected %h", dout1, e1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    freq0 = 1'b0; freq1 = 1'b0;
  endtask

  task automatic apply_reset();
    tick(); reset = 1'b1; idle();
    tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b1; addr0 = 18'd5;
    tick(); mem_init = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (gnt0 !== 1'b0 || ram_we !== 1'b0 || rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL reset_gate: gnt0=%b ram_we=%b rvalid0=%b expected 0 0 0", gnt0, ram_we, rvalid0);
    end
    tick(); reset = 1'b0; idle();
    @(negedge clock);
    n_cmp++;
    if (dout0 !== 18'h0 || dout1 !== 18'h0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || gnt0 !== 1'b0) begin
      n_err++; $display("FAIL reset_state: dout0=%h dout1=%h rv=%b%b gnt0=%b expected zeros", dout0, dout1, rvalid0, rvalid1, gnt0);
    end
  endtask

  task automatic test_single_read();
    tick(); req0 = 1'b1; we0 = 1'b0; addr0 = 18'd5;
    @(negedge clock);
    n_cmp++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_addr !== 18'd5 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL single_gnt: gnt0=%b gnt1=%b addr=%h we=%b expected 1 0 5 0", gnt0, gnt1, ram_addr, ram_we);
    end
    q0.push_back(18'h01234);
    tick(); idle();
    @(negedge clock);
    n_cmp++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || dout1 !== 18'h0) begin
      n_err++; $display("FAIL single_ret: rvalid0=%b rvalid1=%b dout1=%h expected 1 0 0", rvalid0, rvalid1, dout1);
    end
  endtask

  task automatic test_round_robin();
    logic prev;
    logic win;
    prev = 1'b0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      req0 = 1'b1; we0 = 1'b0; addr0 = 18'd20;
      req1 = 1'b1; we1 = 1'b0; addr1 = 18'd21;
      @(negedge clock);
      win = c[0];
      n_cmp++;
      if (gnt0 !== ~win || gnt1 !== win) begin
        n_err++; $display("FAIL rr_gnt[%0d]: gnt0=%b gnt1=%b expected %b %b", c, gnt0, gnt1, ~win, win);
      end
      if (win) q1.push_back(18'h15555); else q0.push_back(18'h0aaaa);
      if (c > 0) begin
        n_cmp++;
        if (rvalid0 !== ~prev || rvalid1 !== prev) begin
          n_err++; $display("FAIL rr_rvalid[%0d]: rvalid0=%b rvalid1=%b expected %b %b", c, rvalid0, rvalid1, ~prev, prev);
        end
      end
      prev = win;
    end
    tick(); idle();
    @(negedge clock);
    n_cmp++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1) begin
      n_err++; $display("FAIL rr_last: rvalid0=%b rvalid1=%b expected 0 1", rvalid0, rvalid1);
    end
  endtask

  task automatic test_fixed_priority();
    for (int c = 0; c < 5; c++) begin
      tick(); freq0 = 1'b1; freq1 = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (fgnt0 !== 1'b1 || fgnt1 !== 1'b0) begin
        n_err++; $display("FAIL fp_starve[%0d]: gnt0=%b gnt1=%b expected 1 0", c, fgnt0, fgnt1);
      end
    end
    tick(); freq0 = 1'b0; freq1 = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (fgnt0 !== 1'b0 || fgnt1 !== 1'b1) begin
      n_err++; $display("FAIL fp_release: gnt0=%b gnt1=%b expected 0 1", fgnt0, fgnt1);
    end
    tick(); idle();
  endtask

  task automatic test_write_then_read();
    tick(); req1 = 1'b1; we1 = 1'b1; addr1 = 18'd7; din1 = 18'h3ffff;
    @(negedge clock);
    n_cmp++;
    if (gnt1 !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 18'd7 || ram_din !== 18'h3ffff) begin
      n_err++; $display("FAIL wr_issue: gnt1=%b we=%b addr=%h din=%h expected 1 1 7 3ffff", gnt1, ram_we, ram_addr, ram_din);
    end
    tick(); req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 18'd7;
    @(negedge clock);
    n_cmp++;
    if (gnt0 !== 1'b1 || rvalid1 !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL raw_issue: gnt0=%b rvalid1=%b we=%b expected 1 0 0", gnt0, rvalid1, ram_we);
    end
    q0.push_back(18'h3ffff);
    tick(); idle();
    @(negedge clock);
    n_cmp++;
    if (rvalid0 !== 1'b1 || dout0 !== 18'h3ffff || rvalid1 !== 1'b0) begin
      n_err++; $display("FAIL raw_ret: rvalid0=%b dout0=%h rvalid1=%b expected 1 3ffff 0", rvalid0, dout0, rvalid1);
    end
  endtask

  task automatic test_reset_inflight();
    tick(); req0 = 1'b1; we0 = 1'b0; addr0 = 18'd5;
    @(negedge clock);
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_err++; $display("FAIL rst_inflight_gnt: gnt0=%b expected 1", gnt0);
    end
    tick(); reset = 1'b1; idle();
    @(negedge clock);
    n_cmp++;
    if (rvalid0 !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL rst_drop: rvalid0=%b ram_we=%b expected 0 0", rvalid0, ram_we);
    end
    tick(); reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (rvalid0 !== 1'b0 || dout0 !== 18'h0 || dout1 !== 18'h0) begin
      n_err++; $display("FAIL rst_clear: rvalid0=%b dout0=%h dout1=%h expected 0 0 0", rvalid0, dout0, dout1);
    end
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 18'd21;
    @(negedge clock);
    n_cmp++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      n_err++; $display("FAIL rst_first_win: gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
    end
    q0.push_back(18'h01234);
    tick(); idle();
  endtask

  task automatic test_hold();
    int pulses;
    pulses = 0;
    tick(); req0 = 1'b1; we0 = 1'b0; addr0 = 18'd3;
    @(negedge clock);
    if (rvalid0 === 1'b1) pulses++;
    q0.push_back(18'h00011);
    for (int c = 0; c < 10; c++) begin
      tick(); idle();
      @(negedge clock);
      if (rvalid0 === 1'b1) pulses++;
      n_cmp++;
      if (dout0 !== 18'h00011 || ram_we !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d]: dout0=%h ram_we=%b expected 00011 0", c, dout0, ram_we);
      end
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL hold_pulses: rvalid0 pulses=%0d expected 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_then_read();
    test_reset_inflight();
    test_hold();
    tick();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL sb_drain: outstanding q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
